router_fifo: RTL and testbench

- Parametrised successor to the single-stage 4-channel packet router.
- Accepts one packet per cycle on a valid/ready input port and decodes the destination field in the top bits.
- Queues each packet in a per-channel first-word-fall-through FIFO, and each channel drains independently through its own valid/ready handshake.
- Discards packets with an illegal destination and counts them.

---
 rtl/router_fifo_if.sv | 28 ++
 rtl/router_fifo.sv | 107 ++++++++++
 tb/tb_router_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Packet router bus: one valid/ready input port and NUM_CH independent
// valid/ready output channels, plus per-channel full flags and a drop counter.
interface router_fifo_if #(
  parameter int DEST_W = 3,
  parameter int DATA_W = 40,
  parameter int NUM_CH = 4
);
  localparam int PKT_W = DEST_W + DATA_W;

  logic                    in_valid;
  logic [PKT_W-1:0]        in_pkt;
  logic                    in_ready;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH*PKT_W-1:0] out_pkt;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH-1:0]       ch_full;
  logic [15:0]             drop_count;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt, ch_full, drop_count
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt, ch_full, drop_count
  );
endinterface

// File: rtl/router_fifo.sv
// Destination-decoding packet router with one first-word-fall-through FIFO
// per output channel; packets with an illegal destination are counted and dropped.
module router_fifo #(
  parameter int DEST_W = 3,
  parameter int DATA_W = 40,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  router_fifo_if.slave bus
);
  localparam int PKT_W = DEST_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PKT_W-1:0]        mem_r    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r [NUM_CH];
  logic [PTR_W-1:0]        rd_ptr_r [NUM_CH];
  logic [CNT_W-1:0]        count_r  [NUM_CH];
  logic [15:0]             drop_count_r;

  logic [DEST_W-1:0]       dest_s;
  logic                    legal_s;
  logic                    drop_s;
  logic                    ready_s;
  logic [NUM_CH-1:0]       push_s;
  logic [NUM_CH-1:0]       pop_s;
  logic [NUM_CH-1:0]       full_s;
  logic [NUM_CH-1:0]       valid_s;
  logic [NUM_CH*PKT_W-1:0] out_pkt_s;

  assign dest_s  = bus.in_pkt[PKT_W-1 -: DEST_W];
  assign legal_s = (dest_s != {DEST_W{1'b0}}) && (dest_s <= DEST_W'(NUM_CH));
  assign drop_s  = bus.in_valid && !legal_s;

  // Per-channel handshake decode and head-of-queue presentation.
  always_comb begin
    ready_s   = 1'b1;
    push_s    = {NUM_CH{1'b0}};
    pop_s     = {NUM_CH{1'b0}};
    full_s    = {NUM_CH{1'b0}};
    valid_s   = {NUM_CH{1'b0}};
    out_pkt_s = {(NUM_CH*PKT_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      full_s[i]  = (count_r[i] == CNT_W'(DEPTH));
      valid_s[i] = (count_r[i] != {CNT_W{1'b0}});
      pop_s[i]   = valid_s[i] && bus.out_ready[i];
      // A full channel refuses even when it pops this cycle: no full-pop bypass.
      if (dest_s == DEST_W'(i + 1)) begin
        ready_s   = !full_s[i];
        push_s[i] = bus.in_valid && !full_s[i];
      end else begin
        push_s[i] = 1'b0;
      end
      if (valid_s[i]) begin
        out_pkt_s[i*PKT_W +: PKT_W] = mem_r[i][rd_ptr_r[i]];
      end else begin
        out_pkt_s[i*PKT_W +: PKT_W] = {PKT_W{1'b0}};
      end
    end
  end

  // FIFO storage; contents are don't-care until occupancy marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= bus.in_pkt;
      end
    end
  end

  // Pointers, occupancy counts and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
      drop_count_r <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
    end
  end

  assign bus.in_ready   = ready_s;
  assign bus.out_valid  = valid_s;
  assign bus.out_pkt    = out_pkt_s;
  assign bus.ch_full    = full_s;
  assign bus.drop_count = drop_count_r;
endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: the driver queues expected packets per
// channel on acceptance, and a monitor compares every popped head against them.
module tb_router_fifo;
  localparam int DEST_W = 3;
  localparam int DATA_W = 40;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int PKT_W  = DEST_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_fifo_if #(.DEST_W(DEST_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  router_fifo #(.DEST_W(DEST_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;
  logic [PKT_W-1:0] exp_q [NUM_CH][$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input int d, input int s);
    mk = {DEST_W'(d), 8'h11, 8'h22, 8'(d), 8'(s * 3), 8'(s)};
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic send(input logic [PKT_W-1:0] pkt, output int waited);
    logic [DEST_W-1:0] d;
    waited = 0;
    @(negedge clk);
    if (rand_ready) bus.out_ready = NUM_CH'($urandom);
    bus.in_valid = 1'b1;
    bus.in_pkt   = pkt;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = NUM_CH'($urandom);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for pkt %0h", pkt);
      bus.in_valid = 1'b0;
      return;
    end
    d = pkt[PKT_W-1 -: DEST_W];
    if (d >= 1 && d <= NUM_CH) exp_q[d-1].push_back(pkt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = {NUM_CH{1'b1}};
    while (pending() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("drain_empty", 256'(pending()), 256'd0);
    check("drain_valid", 256'(bus.out_valid), 256'd0);
  endtask

  // Monitor: every head that is popped must match the scoreboard front.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pop ch%0d: got %0h expected none", i, bus.out_pkt[i*PKT_W +: PKT_W]);
          end else begin
            check($sformatf("ch%0d_order", i), 256'(bus.out_pkt[i*PKT_W +: PKT_W]), 256'(exp_q[i].pop_front()));
          end
        end else if (!bus.out_valid[i]) begin
          check($sformatf("ch%0d_empty_zero", i), 256'(bus.out_pkt[i*PKT_W +: PKT_W]), 256'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PKT_W-1:0] p;
    int w;
    int dests [20] = '{1, 2, 3, 4, 1, 2, 3, 4, 2, 1, 4, 3, 0, 1, 2, 0, 3, 0, 4, 0};

    bus.in_valid  = 1'b0;
    bus.in_pkt    = {PKT_W{1'b0}};
    bus.out_ready = {NUM_CH{1'b0}};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check("rst_out_pkt", 256'(bus.out_pkt), 256'd0);
    check("rst_ch_full", 256'(bus.ch_full), 256'd0);
    check("rst_drop_count", 256'(bus.drop_count), 256'd0);
    check("rst_in_ready", 256'(bus.in_ready), 256'd1);

    // Single route to channel 1.
    bus.out_ready = 4'b1111;
    p = {3'd2, 8'd170, 8'd153, 8'd26, 8'd104, 8'd1};
    send(p, w);
    check("t1_valid", 256'(bus.out_valid), 256'h2);
    check("t1_slice1", 256'(bus.out_pkt[1*PKT_W +: PKT_W]), 256'(p));
    check("t1_slice0", 256'(bus.out_pkt[0 +: PKT_W]), 256'd0);
    check("t1_slice23", 256'(bus.out_pkt[2*PKT_W +: 2*PKT_W]), 256'd0);
    idle();
    @(posedge clk);
    #1;
    check("t1_valid_after", 256'(bus.out_valid), 256'd0);

    // Drops: dest 0 and dest 5.
    send({3'd0, 8'd83, 8'd168, 8'd159, 8'd92, 8'd13}, w);
    check("t2_ready0", 256'(w), 256'd0);
    check("t2_drop1", 256'(bus.drop_count), 256'd1);
    check("t2_valid1", 256'(bus.out_valid), 256'd0);
    send({3'd5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd14}, w);
    check("t2_ready1", 256'(w), 256'd0);
    check("t2_drop2", 256'(bus.drop_count), 256'd2);
    check("t2_valid2", 256'(bus.out_valid), 256'd0);
    idle();
    drain();

    // Full channel 3 with backpressure, other destinations unaffected.
    bus.out_ready = 4'b0111;
    for (int s = 1; s <= 4; s++) send(mk(4, s), w);
    idle();
    #2;
    check("t3_full", 256'(bus.ch_full), 256'h8);
    bus.in_valid = 1'b1;
    bus.in_pkt   = mk(4, 5);
    #1;
    check("t3_blocked", 256'(bus.in_ready), 256'd0);
    send(mk(1, 50), w);
    check("t3_other_ch", 256'(w), 256'd0);
    bus.out_ready = 4'b1111;
    send(mk(4, 5), w);
    check("t3_seq5_wait", 256'(w), 256'd1);
    idle();
    drain();

    // Channel 1 holds two entries while pushes and pops overlap.
    bus.out_ready = 4'b1101;
    send(mk(2, 1), w);
    send(mk(2, 2), w);
    bus.out_ready = 4'b1111;
    for (int s = 3; s <= 8; s++) begin
      send(mk(2, s), w);
      check("t4_no_wait", 256'(w), 256'd0);
      check("t4_not_full", 256'(bus.ch_full[1]), 256'd0);
      check("t4_valid", 256'(bus.out_valid[1]), 256'd1);
    end
    idle();
    drain();

    // Reset with channel 0 partially loaded.
    bus.out_ready = 4'b0000;
    for (int s = 1; s <= 3; s++) send(mk(1, s), w);
    idle();
    rst = 1'b1;
    bus.in_pkt = mk(1, 9);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    #1;
    check("t5_valid", 256'(bus.out_valid), 256'd0);
    check("t5_pkt", 256'(bus.out_pkt), 256'd0);
    check("t5_drop", 256'(bus.drop_count), 256'd0);
    check("t5_ready", 256'(bus.in_ready), 256'd1);
    bus.out_ready = 4'b1111;
    send(mk(3, 7), w);
    check("t5_alone", 256'(bus.out_valid), 256'h4);
    idle();
    drain();

    // 20-packet stream with random consumer readiness.
    rand_ready = 1'b1;
    for (int s = 1; s <= 20; s++) send(mk(dests[s-1], s), w);
    idle();
    rand_ready = 1'b0;
    drain();
    check("t6_drop", 256'(bus.drop_count), 256'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
